sel_controller: RTL and testbench

SEL_CONTROLLER -- requirements
Module: sel_controller

---
 rtl/btn_debounce.sv | 32 +++
 rtl/sel_controller.sv | 40 ++++
 tb/tb_sel_controller.sv | 122 ++++++++++++
 3 files changed

// File: rtl/btn_debounce.sv
// btn_debounce: two-flop synchronizer, counting debouncer and press (debounced rising edge) detect
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN,
  output logic PRESS
);
  localparam int W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [W-1:0] LAST = W'(DEBOUNCE_CYCLES - 1);
  logic s1, s2, deb, deb_q;
  logic [W-1:0] cnt;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      deb <= 1'b0;
      deb_q <= 1'b0;
      cnt <= '0;
    end else begin
      s1 <= BTN;
      s2 <= s1;
      deb_q <= deb;
      if (s2 == deb) cnt <= '0;
      else if (cnt == LAST) begin
        deb <= s2;
        cnt <= '0;
      end else cnt <= cnt + 1'b1;
    end
  assign PRESS = deb & ~deb_q;
endmodule

// File: rtl/sel_controller.sv
// sel_controller: manual/auto 2:1 select controller driven by two debounced push buttons
module sel_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int AUTO_PERIOD = 25000000
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic BTN_TOGGLE,
  input  logic BTN_AUTO,
  output logic SEL,
  output logic AUTO_ACTIVE,
  output logic SEL_CHANGED
);
  localparam logic MANUAL = 1'b0;
  localparam logic AUTO = 1'b1;
  localparam int W = $clog2(AUTO_PERIOD);
  localparam logic [W-1:0] TC = W'(AUTO_PERIOD - 1);
  logic tog, aut, tc, flip, state, state_nx;
  logic [W-1:0] pcnt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_tog (.CLK(CLK), .RST_N(RST_N), .BTN(BTN_TOGGLE), .PRESS(tog));
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_aut (.CLK(CLK), .RST_N(RST_N), .BTN(BTN_AUTO), .PRESS(aut));
  // leaving AUTO holds SEL, so a terminal count coinciding with the exit press is dropped
  assign tc = (state == AUTO) && (pcnt == TC);
  assign flip = tog | (tc & ~aut);
  assign state_nx = aut ? ~state : state;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      state <= MANUAL;
      pcnt <= '0;
      SEL <= 1'b0;
      AUTO_ACTIVE <= 1'b0;
      SEL_CHANGED <= 1'b0;
    end else begin
      state <= state_nx;
      AUTO_ACTIVE <= state_nx == AUTO;
      SEL <= SEL ^ flip;
      SEL_CHANGED <= flip;
      pcnt <= (state_nx == MANUAL || tog || aut || tc) ? '0 : pcnt + 1'b1;
    end
endmodule

// File: tb/tb_sel_controller.sv
// tb_sel_controller: directed scoreboard bench for sel_controller with DEBOUNCE_CYCLES=4, AUTO_PERIOD=8
module tb_sel_controller;
  logic CLK = 1'b0;
  logic RST_N = 1'b0;
  logic BTN_TOGGLE = 1'b0;
  logic BTN_AUTO = 1'b0;
  logic SEL, AUTO_ACTIVE, SEL_CHANGED;
  int tests = 0;
  int fails = 0;
  int cyc = 0;
  logic [2:0] sb[$];
  logic s;

  sel_controller #(.DEBOUNCE_CYCLES(4), .AUTO_PERIOD(8)) dut (
    .CLK(CLK), .RST_N(RST_N), .BTN_TOGGLE(BTN_TOGGLE), .BTN_AUTO(BTN_AUTO),
    .SEL(SEL), .AUTO_ACTIVE(AUTO_ACTIVE), .SEL_CHANGED(SEL_CHANGED)
  );

  always #5 CLK = ~CLK;

  // vectors are {SEL, SEL_CHANGED, AUTO_ACTIVE}
  task automatic chk(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [2:0] e;
    @(posedge CLK);
    #1;
    cyc++;
    if (sb.size() == 0) chk($sformatf("%s_sb_empty_c%0d", tag, cyc), {SEL, SEL_CHANGED, AUTO_ACTIVE}, 3'bxxx);
    else begin
      e = sb.pop_front();
      chk($sformatf("%s_c%0d", tag, cyc), {SEL, SEL_CHANGED, AUTO_ACTIVE}, e);
    end
  endtask

  task automatic run(input string tag, input int n, input logic es, input logic ec, input logic ea);
    repeat (n) sb.push_back({es, ec, ea});
    repeat (n) tick(tag);
  endtask

  initial begin
    repeat (2) @(posedge CLK);
    #1;
    chk("reset", {SEL, SEL_CHANGED, AUTO_ACTIVE}, 3'b000);
    RST_N = 1'b1;
    run("idle", 3, 0, 0, 0);
    // bounce: 3 high, 1 low, 3 high never reaches 4 stable cycles
    BTN_TOGGLE = 1'b1;
    run("bounce", 3, 0, 0, 0);
    BTN_TOGGLE = 1'b0;
    run("bounce", 1, 0, 0, 0);
    BTN_TOGGLE = 1'b1;
    run("bounce", 3, 0, 0, 0);
    BTN_TOGGLE = 1'b0;
    run("bounce", 10, 0, 0, 0);
    // clean press: first sampling edge is 1, flip lands on edge 7
    BTN_TOGGLE = 1'b1;
    run("press", 6, 0, 0, 0);
    run("press_flip", 1, 1, 1, 0);
    run("press_hold", 5, 1, 0, 0);
    BTN_TOGGLE = 1'b0;
    run("release", 10, 1, 0, 0);
    // enter auto, four periods of 8
    BTN_AUTO = 1'b1;
    run("auto_in", 6, 1, 0, 0);
    run("auto_in", 1, 1, 0, 1);
    BTN_AUTO = 1'b0;
    s = 1'b1;
    for (int i = 0; i < 4; i++) begin
      run("auto_wait", 7, s, 0, 1);
      s = ~s;
      run("auto_flip", 1, s, 1, 1);
    end
    BTN_AUTO = 1'b1;
    run("auto_out", 6, s, 0, 1);
    run("auto_out", 1, s, 0, 0);
    BTN_AUTO = 1'b0;
    run("frozen", 12, s, 0, 0);
    // re-enter auto, toggle press lands on the terminal count edge
    BTN_AUTO = 1'b1;
    run("auto_in2", 6, s, 0, 0);
    run("auto_in2", 1, s, 0, 1);
    BTN_AUTO = 1'b0;
    run("coincide", 1, s, 0, 1);
    BTN_TOGGLE = 1'b1;
    run("coincide", 6, s, 0, 1);
    s = ~s;
    run("coincide_flip", 1, s, 1, 1);
    BTN_TOGGLE = 1'b0;
    run("coincide_next", 7, s, 0, 1);
    s = ~s;
    run("coincide_next_flip", 1, s, 1, 1);
    run("mid_period", 3, s, 0, 1);
    // asynchronous reset mid-period with SEL=1
    RST_N = 1'b0;
    #2;
    chk("async_reset", {SEL, SEL_CHANGED, AUTO_ACTIVE}, 3'b000);
    repeat (2) @(posedge CLK);
    #1;
    RST_N = 1'b1;
    run("post_reset", 20, 0, 0, 0);
    // button held through reset release
    BTN_TOGGLE = 1'b1;
    RST_N = 1'b0;
    repeat (3) @(posedge CLK);
    #1;
    chk("held_reset", {SEL, SEL_CHANGED, AUTO_ACTIVE}, 3'b000);
    RST_N = 1'b1;
    run("held", 6, 0, 0, 0);
    run("held_flip", 1, 1, 1, 0);
    run("held_steady", 15, 1, 0, 0);
    BTN_TOGGLE = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
